// File: rtl/lfib_rand_pkg.sv
// Shared definitions for the lagged-Fibonacci random generator:
// combine-mode encodings, FSM state type and warm-up counter width.
package lfib_rand_pkg;

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_XOR = 2'd2;

  localparam int WARM_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_SEED   = 2'd2
  } lfib_state_t;

endpackage

// File: rtl/lfib_tap_reg.sv
// Lagged-Fibonacci register array: seed shift-in, tap selection and combine.
// r[0] is the newest word and is presented directly on dout.
module lfib_tap_reg #(
  parameter int WIDTH = 32,
  parameter int LAG_K = 55,
  parameter int LAG_J = 24,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_in,
  input  logic             advance,
  input  logic [WIDTH-1:0] seed_data,
  output logic [WIDTH-1:0] dout
);
  import lfib_rand_pkg::*;

  localparam logic [1:0] MODE_SEL = 2'(MODE);

  logic [WIDTH-1:0] r [LAG_K];
  logic [WIDTH-1:0] new_word;

  // Combine the long-lag and short-lag taps into the next word.
  always_comb begin
    new_word = {WIDTH{1'b0}};
    case (MODE_SEL)
      MODE_ADD: new_word = r[LAG_K-1] + r[LAG_J-1];
      MODE_SUB: new_word = r[LAG_K-1] - r[LAG_J-1];
      MODE_XOR: new_word = r[LAG_K-1] ^ r[LAG_J-1];
      default:  new_word = r[LAG_K-1] ^ r[LAG_J-1];
    endcase
  end

  // Seed words take priority over generated words; both use the same shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAG_K; i++) begin
        r[i] <= {WIDTH{1'b1}};
      end
    end else if (shift_in || advance) begin
      for (int i = LAG_K - 1; i > 0; i--) begin
        r[i] <= r[i-1];
      end
      r[0] <= shift_in ? seed_data : new_word;
    end
  end

  assign dout = r[0];

endmodule

// File: rtl/lfib_rand_gen.sv
// Lagged-Fibonacci random word generator with seeding, optional warm-up
// and a valid/ready output handshake.
module lfib_rand_gen #(
  parameter int WIDTH         = 32,
  parameter int LAG_K         = 55,
  parameter int LAG_J         = 24,
  parameter int MODE          = 0,
  parameter int WARMUP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_data,
  input  logic             seed_last,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy
);
  import lfib_rand_pkg::*;

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("lfib_rand_gen: WIDTH must be 1..64");
  end
  if (LAG_K < 2 || LAG_J < 1 || LAG_J >= LAG_K) begin : g_bad_lags
    $error("lfib_rand_gen: need LAG_K >= 2 and 1 <= LAG_J < LAG_K");
  end
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("lfib_rand_gen: MODE must be 0, 1 or 2");
  end
  if (WARMUP_CYCLES < 0 || WARMUP_CYCLES > 65535) begin : g_bad_warmup
    $error("lfib_rand_gen: WARMUP_CYCLES must be 0..65535");
  end

  localparam lfib_state_t START_STATE = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;
  localparam logic START_VALID = (WARMUP_CYCLES == 0) ? 1'b1 : 1'b0;
  // Only reachable when WARMUP_CYCLES > 0, so the wrap at zero is harmless.
  localparam logic [WARM_CNT_W-1:0] WARM_LAST = WARM_CNT_W'(WARMUP_CYCLES - 1);

  lfib_state_t           state;
  logic [WARM_CNT_W-1:0] warm_cnt;
  logic                  advance;

  assign advance = ~seed_valid & clk_en &
                   ((state == ST_WARMUP) | ((state == ST_RUN) & dout_ready));

  // Control FSM; dout_valid and busy are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= START_STATE;
      warm_cnt   <= {WARM_CNT_W{1'b0}};
      dout_valid <= START_VALID;
      busy       <= ~START_VALID;
    end else if (seed_valid) begin
      if (seed_last) begin
        state      <= START_STATE;
        warm_cnt   <= {WARM_CNT_W{1'b0}};
        dout_valid <= START_VALID;
        busy       <= ~START_VALID;
      end else begin
        state      <= ST_SEED;
        dout_valid <= 1'b0;
        busy       <= 1'b1;
      end
    end else begin
      case (state)
        ST_WARMUP: begin
          if (clk_en) begin
            if (warm_cnt == WARM_LAST) begin
              state      <= ST_RUN;
              warm_cnt   <= {WARM_CNT_W{1'b0}};
              dout_valid <= 1'b1;
              busy       <= 1'b0;
            end else begin
              warm_cnt <= warm_cnt + {{(WARM_CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_RUN: begin
          dout_valid <= 1'b1;
          busy       <= 1'b0;
        end
        ST_SEED: begin
          dout_valid <= 1'b0;
          busy       <= 1'b1;
        end
        default: begin
          state      <= START_STATE;
          warm_cnt   <= {WARM_CNT_W{1'b0}};
          dout_valid <= START_VALID;
          busy       <= ~START_VALID;
        end
      endcase
    end
  end

  lfib_tap_reg #(
    .WIDTH (WIDTH),
    .LAG_K (LAG_K),
    .LAG_J (LAG_J),
    .MODE  (MODE)
  ) u_tap_reg (
    .clk       (clk),
    .reset     (reset),
    .shift_in  (seed_valid),
    .advance   (advance),
    .seed_data (seed_data),
    .dout      (dout)
  );

endmodule

// File: tb/tb_lfib_rand_gen.sv
// Directed self-checking bench: four generator instances (add, xor, sub,
// add with 4-cycle warm-up) share one stimulus stream.
module tb_lfib_rand_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b0;
  logic        seed_valid = 1'b0;
  logic [31:0] seed_data = 32'd0;
  logic        seed_last = 1'b0;
  logic        dout_ready = 1'b0;

  logic [31:0] add_dout, xor_dout, sub_dout, warm_dout;
  logic        add_valid, xor_valid, sub_valid, warm_valid;
  logic        add_busy, xor_busy, sub_busy, warm_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lfib_rand_gen u_add (
    .clk(clk), .reset(reset), .clk_en(clk_en), .seed_valid(seed_valid),
    .seed_data(seed_data), .seed_last(seed_last), .dout(add_dout),
    .dout_valid(add_valid), .dout_ready(dout_ready), .busy(add_busy)
  );

  lfib_rand_gen #(.MODE(2)) u_xor (
    .clk(clk), .reset(reset), .clk_en(clk_en), .seed_valid(seed_valid),
    .seed_data(seed_data), .seed_last(seed_last), .dout(xor_dout),
    .dout_valid(xor_valid), .dout_ready(dout_ready), .busy(xor_busy)
  );

  lfib_rand_gen #(.MODE(1)) u_sub (
    .clk(clk), .reset(reset), .clk_en(clk_en), .seed_valid(seed_valid),
    .seed_data(seed_data), .seed_last(seed_last), .dout(sub_dout),
    .dout_valid(sub_valid), .dout_ready(dout_ready), .busy(sub_busy)
  );

  lfib_rand_gen #(.WARMUP_CYCLES(4)) u_warm (
    .clk(clk), .reset(reset), .clk_en(clk_en), .seed_valid(seed_valid),
    .seed_data(seed_data), .seed_last(seed_last), .dout(warm_dout),
    .dout_valid(warm_valid), .dout_ready(dout_ready), .busy(warm_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int enabled;
    logic exp_v;

    // Reset state
    step();
    step();
    reset = 1'b0;
    check("rst_add_dout", add_dout, 32'hFFFF_FFFF);
    check("rst_add_valid", {31'd0, add_valid}, 32'd1);
    check("rst_add_busy", {31'd0, add_busy}, 32'd0);
    check("rst_xor_dout", xor_dout, 32'hFFFF_FFFF);
    check("rst_warm_valid", {31'd0, warm_valid}, 32'd0);
    check("rst_warm_busy", {31'd0, warm_busy}, 32'd1);

    // First advance from all-ones in each mode
    clk_en = 1'b1;
    dout_ready = 1'b1;
    step();
    clk_en = 1'b0;
    check("adv1_add", add_dout, 32'hFFFF_FFFE);
    check("adv1_xor", xor_dout, 32'h0000_0000);
    check("adv1_sub", sub_dout, 32'h0000_0000);

    // Warm-up with clk_en on alternate cycles
    reset = 1'b1;
    step();
    reset = 1'b0;
    enabled = 0;
    for (int k = 0; k < 8; k++) begin
      clk_en = (k % 2 == 0);
      if (clk_en) enabled++;
      step();
      exp_v = (enabled >= 4);
      check($sformatf("warm_valid_%0d", k), {31'd0, warm_valid}, {31'd0, exp_v});
      check($sformatf("warm_busy_%0d", k), {31'd0, warm_busy}, {31'd0, ~exp_v});
    end
    clk_en = 1'b0;

    // Full seed 1..55, clk_en low to show seeding ignores it
    for (int w = 1; w <= 55; w++) begin
      seed_valid = 1'b1;
      seed_data = w;
      seed_last = (w == 55);
      step();
      if (w == 1) begin
        check("seed_valid_drop", {31'd0, add_valid}, 32'd0);
        check("seed_busy", {31'd0, add_busy}, 32'd1);
      end
    end
    seed_valid = 1'b0;
    seed_last = 1'b0;
    check("seed_r0", add_dout, 32'd55);
    check("seed_done_valid", {31'd0, add_valid}, 32'd1);
    check("seed_done_busy", {31'd0, add_busy}, 32'd0);

    // First advance after seeding: r[54]=1, r[23]=32
    clk_en = 1'b1;
    dout_ready = 1'b1;
    step();
    check("seed_adv_add", add_dout, 32'd33);
    check("seed_adv_sub", sub_dout, 32'hFFFF_FFE1);
    check("seed_adv_xor", xor_dout, 32'h0000_0021);

    // dout_ready pattern 1,0,0,1: exactly two advances
    dout_ready = 1'b1;
    step();
    check("rdy_1", add_dout, 32'd35);
    dout_ready = 1'b0;
    step();
    check("rdy_0a", add_dout, 32'd35);
    step();
    check("rdy_0b", add_dout, 32'd35);
    dout_ready = 1'b1;
    step();
    check("rdy_1b", add_dout, 32'd37);

    // Seed mid-RUN, a hold cycle in SEED, then reset on the third word
    seed_valid = 1'b1;
    seed_data = 32'd100;
    step();
    check("mid_seed_valid", {31'd0, add_valid}, 32'd0);
    check("mid_seed_dout", add_dout, 32'd100);
    seed_valid = 1'b0;
    step();
    check("seed_hold_dout", add_dout, 32'd100);
    check("seed_hold_valid", {31'd0, add_valid}, 32'd0);
    seed_valid = 1'b1;
    seed_data = 32'd101;
    step();
    check("mid_seed2_dout", add_dout, 32'd101);
    seed_data = 32'd102;
    reset = 1'b1;
    step();
    reset = 1'b0;
    seed_valid = 1'b0;
    check("mid_rst_dout", add_dout, 32'hFFFF_FFFF);
    check("mid_rst_valid", {31'd0, add_valid}, 32'd1);
    check("mid_rst_busy", {31'd0, add_busy}, 32'd0);
    clk_en = 1'b0;
    step();
    check("mid_rst_hold", add_dout, 32'hFFFF_FFFF);
    clk_en = 1'b1;
    dout_ready = 1'b1;
    step();
    check("mid_rst_adv", add_dout, 32'hFFFF_FFFE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lfib_rand_gen.md
LFIB_RAND_GEN -- requirements
Module: lfib_rand_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 32, word width in bits (1..64).
- LAG_K, 55, long lag / register depth (>= 2).
- LAG_J, 24, short lag (1 <= LAG_J < LAG_K).
- MODE, 0, combine function: 0 add, 1 sub, 2 xor.
- WARMUP_CYCLES, 0, advances discarded after reset or seeding (0..65535).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high reset.
- clk_en, in, 1, advance enable.
- seed_valid, in, 1, seed word present.
- seed_data, in, WIDTH, seed word.
- seed_last, in, 1, final seed word.
- dout, out, WIDTH, current random word.
- dout_valid, out, 1, dout is a usable output.
- dout_ready, in, 1, consumer accepts dout.
- busy, out, 1, block is in SEED or WARMUP.
REQ-003 Reset SHALL be reset, synchronous, active-high; clock clk; all state SHALL update on the rising edge of clk only.

Function
REQ-004 State SHALL be a register array r[0..LAG_K-1] of WIDTH bits; r[0] is the newest word; dout SHALL equal r[0] combinationally.
REQ-005 An advance SHALL do r[i] <= r[i-1] for i = 1..LAG_K-1 and r[0] <= f(r[LAG_K-1], r[LAG_J-1]).
REQ-006 The combine function f SHALL be selected by MODE:
- add: a+b mod 2^WIDTH.
- sub: a-b mod 2^WIDTH.
- xor: a^b.
REQ-007 The FSM SHALL have states WARMUP, RUN and SEED.
REQ-008 In WARMUP the block SHALL advance on every cycle with clk_en=1 and increment a warm-up counter; after WARMUP_CYCLES advances it SHALL enter RUN.
REQ-009 If WARMUP_CYCLES=0, WARMUP SHALL be skipped and the block SHALL enter RUN directly.
REQ-010 In RUN, dout_valid SHALL be 1, and the block SHALL advance only on cycles with clk_en=1 and dout_ready=1.
REQ-011 With dout_ready=0 or clk_en=0 in RUN, r SHALL hold and dout SHALL be stable.
REQ-012 In any state, seed_valid=1 SHALL take priority over an advance and SHALL shift seed_data in: r[0] <= seed_data, r[i] <= r[i-1]. This SHALL happen regardless of clk_en, and the state SHALL become SEED.
REQ-013 seed_valid=1 together with seed_last=1 SHALL shift the word, clear the warm-up counter and go to WARMUP (or to RUN if WARMUP_CYCLES=0).
REQ-014 With seed_valid=0 in SEED, the block SHALL hold with no advance.
REQ-015 A seed of fewer than LAG_K words SHALL leave the older entries shifted but otherwise unchanged.
REQ-016 dout_valid SHALL be 0 in SEED and in WARMUP.
REQ-017 busy SHALL equal (state != RUN).
REQ-018 Output latency SHALL be as follows:
- a word accepted at edge n is replaced at edge n;
- the new dout is visible in cycle n+1;
- dout_valid drops in the cycle after the first seed_valid.

Reset
REQ-019 Reset SHALL take priority over seed_valid, clk_en and dout_ready.
REQ-020 Reset SHALL set every r[i] to all-ones and clear the warm-up counter.
REQ-021 Reset SHALL set the state to WARMUP (or RUN if WARMUP_CYCLES=0).
REQ-022 After reset, dout SHALL equal all-ones, and dout_valid SHALL be 1 if WARMUP_CYCLES=0, otherwise 0.
REQ-023 Reset asserted mid-seed or mid-warm-up SHALL abandon that operation with no residue.

Structure
REQ-024 The shared package lfib_rand_pkg SHALL hold:
- MODE encodings (MODE_ADD=0, MODE_SUB=1, MODE_XOR=2);
- the FSM state type;
- the warm-up counter width constant (16).
REQ-025 The register array, tap selection and combine function SHALL live in one sub-module, lfib_tap_reg, with controls shift_in and advance. The FSM and handshake SHALL remain in lfib_rand_gen.
REQ-026 Parameter legality (the LAG_J/LAG_K relation, MODE range) SHALL be checked at elaboration and SHALL cause an error when violated.

Verification
REQ-027 Bench SHALL cover the following directed scenarios:
- Default parameters, reset released, clk_en=1, dout_ready=1 -> dout=FFFFFFFF with dout_valid=1 immediately; the next word is FFFFFFFE.
- MODE=2 and MODE=1 from reset -> the first advanced word is 00000000.
- Seed words 1..55 with seed_last on word 55 -> r[0]=55, r[23]=32, r[54]=1; the first advance gives dout=33 in add mode.
- RUN with dout_ready toggled 1,0,0,1 -> dout holds across the low cycles; exactly two advances occur.
- WARMUP_CYCLES=4, clk_en low on alternate cycles after reset -> dout_valid rises only after the 4th enabled advance; busy=1 until then.
- seed_valid mid-RUN, then reset on the third seed word -> dout_valid=0 the next cycle; after reset r is all-ones, and the state is RUN with WARMUP_CYCLES=0.
